mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage load/store unit between the EX/MEM and MEM/WB pipeline registers.
//  - Issues data-memory accesses over a req/gnt/rvalid bus.
//  - Drives byte enables and store-data lane replication.
//  - Aligns and sign/zero-extends load data into dm_data_mem for MEM/WB.
//  - Stalls the pipeline via mem_stall while an access is outstanding.
// PARAMETERS
//  ADDR_WIDTH      32  width of dm_addr
//  TIMEOUT_CYCLES  16  bus watchdog limit; used only with DM_TIMEOUT_EN
// PORTS
//  clk           in   1   clock
//  rst_n         in   1   synchronous reset, active-low
//  load_mem      in   1   load in MEM stage
//  store_mem     in   1   store in MEM stage (never set together with load_mem)
//  funct3_mem    in   3   RV32I size/sign code
//  alu_data_mem  in   32  effective address
//  rs2_data_mem  in   32  store data
//  dm_req        out  1   bus request
//  dm_we         out  1   1 = write
//  dm_addr       out  AW  word address {addr[AW-1:2],2'b00}
//  dm_be         out  4   byte enables
//  dm_wdata      out  32  lane-replicated store data
//  dm_gnt        in   1   request accepted
//  dm_rvalid     in   1   read data valid
//  dm_rdata      in   32  read word
//  dm_data_mem   out  32  formatted load data, to MEM/WB
//  mem_stall     out  1   hold IF..EX/MEM; MEM/WB takes a bubble
//  misalign_mem  out  1   misaligned access flag (combinational)
//  dm_err        out  1   bus timeout pulse
// BEHAVIOUR
//  - Reset: state IDLE; data register, counter, dm_req, mem_stall and dm_err = 0.
//  - FSM states:
//    - IDLE: access = (load_mem|store_mem) & ~misalign.
//      - dm_req is driven combinationally in the same cycle.
//      - Store + gnt: done in 0 stall cycles; stay in IDLE.
//      - Load + gnt: go to WAIT.
//      - No gnt: go to REQ.
//    - REQ: hold dm_req and all bus outputs stable until gnt.
//      - Store + gnt: go to DONE. Load + gnt: go to WAIT.
//    - WAIT: on rvalid, register the formatted data and go to DONE.
//      - rvalid is only sampled in WAIT; memory returns rvalid >= 1 cycle after gnt.
//    - DONE: mem_stall = 0 for one cycle; MEM/WB captures the register; go to IDLE.
//      - Inputs are ignored in DONE, so the same instruction is never re-issued.
//  - mem_stall = 1 in IDLE when an access lacks gnt, in IDLE on load+gnt, and in REQ/WAIT.
//  - Zero-stall load is impossible; minimum load latency is 2 stall cycles.
//  - Misalign: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
//    - Response: misalign_mem = 1, no dm_req, no stall, dm_data_mem = 0.
//  - Store enables (o = addr[1:0]):
//    - SB: be = 4'b0001<<o, wdata = {4{rs2[7:0]}}
//    - SH: be = 4'b0011<<o, wdata = {2{rs2[15:0]}}
//    - SW: be = 4'b1111
//    - Loads drive be = 4'b1111.
//  - Load format: select byte/half by o.
//    - LB/LH sign-extend; LBU/LHU zero-extend.
//    - funct3 011/110/111 are treated as LW.
//  - dm_data_mem outside DONE: the store-path value, 0.
//  - Reset mid-access: return to IDLE immediately; dm_req drops; a late rvalid is ignored.
// CONFIGURATION
//  DM_TIMEOUT_EN defined:
//   - Counter runs in REQ/WAIT and clears on leaving them.
//   - On reaching TIMEOUT_CYCLES: dm_err pulses 1 cycle; dm_req drops; go to DONE
//     with load data 0.
//  DM_TIMEOUT_EN undefined:
//   - No counter; dm_err is tied 0; REQ/WAIT wait indefinitely.
// TESTING
//  1. LW addr 0x100, gnt same cycle, rvalid 2 cycles later, rdata 0xCAFEBABE
//     -> mem_stall 3 cycles; dm_data_mem = 0xCAFEBABE in DONE.
//  2. LB addr 0x103, rdata 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080.
//  3. SH addr 0x202, rs2 0x1234ABCD, gnt immediate
//     -> be = 4'b1100, wdata = 0xABCDABCD, we = 1, mem_stall = 0.
//  4. SW addr 0x301 -> misalign_mem = 1, dm_req = 0, mem_stall = 0.
//  5. Load with gnt held low 4 cycles
//     -> dm_req/dm_addr stable across the 4 cycles; rst_n low mid-WAIT
//        -> IDLE next cycle, stall = 0.
//  6. DM_TIMEOUT_EN, TIMEOUT_CYCLES = 16, gnt never asserted
//     -> dm_err pulse after 16 cycles in REQ, dm_data_mem = 0, pipeline resumes.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - data-memory req/gnt/rvalid bus between the MEM stage and memory
// Purpose: groups the data-memory bus so the load/store unit and memory share one port.
// Signals:
//   dm_req    request (master -> slave)
//   dm_we     1 = write
//   dm_addr   word-aligned address
//   dm_be     byte enables
//   dm_wdata  lane-replicated store data
//   dm_gnt    request accepted (slave -> master)
//   dm_rvalid read data valid
//   dm_rdata  read word
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  dm_req;
    logic                  dm_we;
    logic [ADDR_WIDTH-1:0] dm_addr;
    logic [3:0]            dm_be;
    logic [31:0]           dm_wdata;
    logic                  dm_gnt;
    logic                  dm_rvalid;
    logic [31:0]           dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store unit with pipeline stall and load formatting
// Purpose: issues data-memory accesses, drives byte enables and replicated store data,
//   aligns and extends load data for MEM/WB, and stalls the pipeline while an access is open.
// Optional feature: define DM_TIMEOUT_EN to enable the bus watchdog (TIMEOUT_CYCLES).
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   load_mem        load in MEM stage
//   store_mem       store in MEM stage
//   funct3_mem      RV32I size/sign code
//   alu_data_mem    effective address
//   rs2_data_mem    store data
//   bus             data-memory bus (master modport)
//   dm_data_mem     formatted load data to MEM/WB
//   mem_stall       pipeline hold
//   misalign_mem    misaligned access flag (combinational)
//   dm_err          bus timeout pulse
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_mem,
    input  logic                     store_mem,
    input  logic [2:0]               funct3_mem,
    input  logic [31:0]              alu_data_mem,
    input  logic [31:0]              rs2_data_mem,
    mem_access_unit_if.master        bus,
    output logic [31:0]              dm_data_mem,
    output logic                     mem_stall,
    output logic                     misalign_mem,
    output logic                     dm_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [3:0]            r_be;
    logic [31:0]           r_wdata;
    logic [2:0]            r_funct3;
    logic [1:0]            r_off;
    logic [31:0]           r_data;

    logic                  w_word;
    logic                  w_half;
    logic [1:0]            w_off;
    logic                  w_misalign;
    logic                  w_access;
    logic [3:0]            w_be_in;
    logic [31:0]           w_wdata_in;
    logic                  w_stall;
    logic                  w_timeout;
    logic                  w_to_fire;
    logic                  w_idle;

    // funct3[1] set means a word access (covers 010 and the 011/110/111 codes treated as LW)
    assign w_word     = funct3_mem[1];
    assign w_half     = ~funct3_mem[1] & funct3_mem[0];
    assign w_off      = alu_data_mem[1:0];
    assign w_misalign = (load_mem | store_mem) &
                        ((w_half & w_off[0]) | (w_word & (w_off != 2'b00)));
    assign w_access   = (load_mem | store_mem) & ~w_misalign;
    assign misalign_mem = w_misalign;
    assign w_idle     = (r_state == S_IDLE);

    always_comb begin
        w_be_in    = 4'b1111;
        w_wdata_in = rs2_data_mem;
        if (store_mem && !w_word) begin
            if (w_half) begin
                w_be_in    = 4'b0011 << w_off;
                w_wdata_in = {2{rs2_data_mem[15:0]}};
            end else begin
                w_be_in    = 4'b0001 << w_off;
                w_wdata_in = {4{rs2_data_mem[7:0]}};
            end
        end
    end

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{off, 3'b000} +: 8];
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b100:  fmt_load = {24'h0, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b101:  fmt_load = {16'h0, h};
            default: fmt_load = d;
        endcase
    endfunction

    // In IDLE the request is driven straight from the inputs; once it leaves IDLE the
    // captured copy keeps the bus stable regardless of what the inputs do.
    assign bus.dm_req   = rst_n & ((w_idle & w_access) | (r_state == S_REQ));
    assign bus.dm_we    = w_idle ? store_mem : r_we;
    assign bus.dm_addr  = w_idle ? {alu_data_mem[ADDR_WIDTH-1:2], 2'b00} : r_addr;
    assign bus.dm_be    = w_idle ? w_be_in : r_be;
    assign bus.dm_wdata = w_idle ? w_wdata_in : r_wdata;

    assign mem_stall   = rst_n & w_stall;
    assign dm_data_mem = (r_state == S_DONE) ? r_data : 32'h0;

    always_comb begin
        w_next    = r_state;
        w_stall   = 1'b0;
        w_to_fire = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    if (bus.dm_gnt) begin
                        if (load_mem) begin
                            w_next  = S_WAIT;
                            w_stall = 1'b1;
                        end
                    end else begin
                        w_next  = S_REQ;
                        w_stall = 1'b1;
                    end
                end
            end
            S_REQ: begin
                w_stall = 1'b1;
                if (bus.dm_gnt) begin
                    w_next = r_we ? S_DONE : S_WAIT;
                end else if (w_timeout) begin
                    w_next    = S_DONE;
                    w_to_fire = 1'b1;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (bus.dm_rvalid) begin
                    w_next = S_DONE;
                end else if (w_timeout) begin
                    w_next    = S_DONE;
                    w_to_fire = 1'b1;
                end
            end
            S_DONE: begin
                // one release cycle; inputs still show the finished instruction, so ignore them
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_be     <= 4'h0;
            r_wdata  <= 32'h0;
            r_funct3 <= 3'h0;
            r_off    <= 2'h0;
            r_data   <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_idle && w_access) begin
                r_we     <= store_mem;
                r_addr   <= {alu_data_mem[ADDR_WIDTH-1:2], 2'b00};
                r_be     <= w_be_in;
                r_wdata  <= w_wdata_in;
                r_funct3 <= funct3_mem;
                r_off    <= w_off;
                r_data   <= 32'h0;
            end
            if (r_state == S_WAIT && bus.dm_rvalid) begin
                r_data <= fmt_load(r_funct3, r_off, bus.dm_rdata);
            end
            if (w_to_fire) begin
                r_data <= 32'h0;
            end
        end
    end

`ifdef DM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          w_busy;

    assign w_busy    = (r_state == S_REQ) || (r_state == S_WAIT);
    // >= rather than == so a late grant on the last REQ cycle still times out in WAIT
    assign w_timeout = w_busy && (r_cnt >= CW'(TIMEOUT_CYCLES - 1));
    assign dm_err    = r_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_to_fire;
            if (w_busy && (w_next == S_REQ || w_next == S_WAIT)) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign dm_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_mem;
    logic        store_mem;
    logic [2:0]  funct3_mem;
    logic [31:0] alu_data_mem;
    logic [31:0] rs2_data_mem;
    logic [31:0] dm_data_mem;
    logic        mem_stall;
    logic        misalign_mem;
    logic        dm_err;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_WIDTH(32)) bus ();

    mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_mem     (load_mem),
        .store_mem    (store_mem),
        .funct3_mem   (funct3_mem),
        .alu_data_mem (alu_data_mem),
        .rs2_data_mem (rs2_data_mem),
        .bus          (bus),
        .dm_data_mem  (dm_data_mem),
        .mem_stall    (mem_stall),
        .misalign_mem (misalign_mem),
        .dm_err       (dm_err)
    );

    int total = 0;
    int bad   = 0;

    logic        exp_chk = 1'b0;
    logic        exp_req, exp_we, exp_stall, exp_mis;
    logic [31:0] exp_addr, exp_wdata, exp_data;
    logic [3:0]  exp_be;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_chk) begin
            chk("req", {31'h0, bus.dm_req}, {31'h0, exp_req});
            chk("stall", {31'h0, mem_stall}, {31'h0, exp_stall});
            chk("misalign", {31'h0, misalign_mem}, {31'h0, exp_mis});
            chk("data", dm_data_mem, exp_data);
            chk("err", {31'h0, dm_err}, 32'h0);
            if (exp_req) begin
                chk("we", {31'h0, bus.dm_we}, {31'h0, exp_we});
                chk("addr", bus.dm_addr, exp_addr);
                chk("be", {28'h0, bus.dm_be}, {28'h0, exp_be});
                if (exp_we) chk("wdata", bus.dm_wdata, exp_wdata);
            end
        end
    end

    // One instruction: g = cycles before gnt, r = cycles from gnt to rvalid (>= 1).
    task automatic do_instr(input logic ld, input logic st, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input int g, input int r, input logic [31:0] rd,
                            output logic [31:0] got_data, output int stalls,
                            output logic [3:0] got_be, output logic [31:0] got_wd,
                            output logic got_mis, output logic got_req);
        int          nb, n, o;
        logic        mis, act;
        logic [31:0] v, ex_wd;
        logic [3:0]  ex_be;
        nb  = f3[1] ? 4 : (f3[0] ? 2 : 1);
        o   = int'(addr % 4);
        mis = (ld | st) && ((addr % nb) != 0);
        act = (ld | st) && !mis;
        if (ld || nb == 4)  ex_be = 4'hF;
        else if (nb == 2)   ex_be = 4'(3 << o);
        else                ex_be = 4'(1 << o);
        if (nb == 1)        ex_wd = {24'h0, rs2[7:0]} * 32'h01010101;
        else if (nb == 2)   ex_wd = {16'h0, rs2[15:0]} * 32'h00010001;
        else                ex_wd = rs2;
        v = rd >> (8 * o);
        if (nb == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
        end else if (nb == 2) begin
            v = v & 32'hFFFF;
            if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
        end
        if (!act)           n = 1;
        else if (st)        n = (g == 0) ? 1 : g + 2;
        else                n = g + r + 2;
        load_mem     = ld;
        store_mem    = st;
        funct3_mem   = f3;
        alu_data_mem = addr;
        rs2_data_mem = rs2;
        stalls   = 0;
        got_be   = 4'h0;
        got_wd   = 32'h0;
        got_mis  = 1'b0;
        got_req  = 1'b0;
        got_data = 32'h0;
        for (int k = 0; k < n; k++) begin
            exp_mis   = mis;
            exp_we    = st;
            exp_addr  = {addr[31:2], 2'b00};
            exp_be    = ex_be;
            exp_wdata = ex_wd;
            exp_req   = act && (k <= g);
            exp_stall = act && (ld || g > 0) && (k < n - 1);
            exp_data  = (act && ld && k == n - 1) ? v : 32'h0;
            bus.dm_gnt    = act ? (k == g) : 1'($urandom % 2);
            bus.dm_rvalid = act && ld && (k == g + r);
            bus.dm_rdata  = bus.dm_rvalid ? rd : $urandom;
            @(negedge clk);
            if (mem_stall) stalls++;
            if (k == 0) begin
                got_be  = bus.dm_be;
                got_wd  = bus.dm_wdata;
                got_mis = misalign_mem;
                got_req = bus.dm_req;
            end
            got_data = dm_data_mem;
            @(posedge clk);
            #1;
        end
        load_mem      = 1'b0;
        store_mem     = 1'b0;
        bus.dm_gnt    = 1'b0;
        bus.dm_rvalid = 1'b0;
    endtask

    initial begin
        logic [31:0] d, wd, a;
        logic [3:0]  be;
        logic [2:0]  f3;
        logic        m, q, ld, st;
        int          s, sel;
        rst_n         = 1'b0;
        load_mem      = 1'b0;
        store_mem     = 1'b0;
        funct3_mem    = 3'h0;
        alu_data_mem  = 32'h0;
        rs2_data_mem  = 32'h0;
        bus.dm_gnt    = 1'b0;
        bus.dm_rvalid = 1'b0;
        bus.dm_rdata  = 32'h0;
        exp_req = 1'b0; exp_we = 1'b0; exp_stall = 1'b0; exp_mis = 1'b0;
        exp_addr = 32'h0; exp_wdata = 32'h0; exp_data = 32'h0; exp_be = 4'h0;
        @(posedge clk);
        #1;
        exp_chk = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        do_instr(1, 0, 3'b010, 32'h100, 32'h0, 0, 2, 32'hCAFEBABE, d, s, be, wd, m, q);
        chk("lw_data", d, 32'hCAFEBABE);
        chk("lw_stalls", s, 3);
        do_instr(1, 0, 3'b000, 32'h103, 32'h0, 0, 1, 32'h80112233, d, s, be, wd, m, q);
        chk("lb_data", d, 32'hFFFFFF80);
        do_instr(1, 0, 3'b100, 32'h103, 32'h0, 1, 1, 32'h80112233, d, s, be, wd, m, q);
        chk("lbu_data", d, 32'h00000080);
        do_instr(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 1, 32'h0, d, s, be, wd, m, q);
        chk("sh_be", {28'h0, be}, 32'hC);
        chk("sh_wdata", wd, 32'hABCDABCD);
        chk("sh_stalls", s, 0);
        do_instr(0, 1, 3'b010, 32'h301, 32'h55, 0, 1, 32'h0, d, s, be, wd, m, q);
        chk("sw_mis_flag", {31'h0, m}, 32'h1);
        chk("sw_mis_req", {31'h0, q}, 32'h0);
        chk("sw_mis_stalls", s, 0);
        do_instr(1, 0, 3'b101, 32'h402, 32'h0, 4, 1, 32'h9ABC1234, d, s, be, wd, m, q);
        chk("lhu_slow_data", d, 32'h00009ABC);
        chk("lhu_slow_stalls", s, 6);

        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom % 5);
            ld  = (sel == 1 || sel == 2);
            st  = (sel >= 3);
            f3  = st ? 3'($urandom % 3) : 3'($urandom % 8);
            a   = $urandom;
            if ($urandom % 4 != 0) a = a & 32'hFFFFFFFC;
            do_instr(ld, st, f3, a, $urandom, int'($urandom % 4), int'(1 + $urandom % 3),
                     $urandom, d, s, be, wd, m, q);
        end

        // reset while waiting for read data; a late rvalid must not produce a result
        exp_chk      = 1'b0;
        load_mem     = 1'b1;
        funct3_mem   = 3'b010;
        alu_data_mem = 32'h40;
        bus.dm_gnt   = 1'b1;
        @(posedge clk);
        #1;
        bus.dm_gnt = 1'b0;
        @(negedge clk);
        chk("wait_stall", {31'h0, mem_stall}, 32'h1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n         = 1'b1;
        load_mem      = 1'b0;
        bus.dm_rvalid = 1'b1;
        bus.dm_rdata  = 32'h12345678;
        @(negedge clk);
        chk("rst_stall", {31'h0, mem_stall}, 32'h0);
        chk("rst_req", {31'h0, bus.dm_req}, 32'h0);
        chk("rst_data", dm_data_mem, 32'h0);
        @(posedge clk);
        #1;
        bus.dm_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_data", dm_data_mem, 32'h0);
        chk("late_rvalid_stall", {31'h0, mem_stall}, 32'h0);
        @(posedge clk);
        #1;

`ifdef DM_TIMEOUT_EN
        begin
            int  at;
            logic found;
            found        = 1'b0;
            at           = -1;
            load_mem     = 1'b1;
            funct3_mem   = 3'b010;
            alu_data_mem = 32'h80;
            for (int k = 0; k < 40 && !found; k++) begin
                @(negedge clk);
                if (dm_err) begin
                    found = 1'b1;
                    at    = k;
                    chk("to_data", dm_data_mem, 32'h0);
                    chk("to_stall", {31'h0, mem_stall}, 32'h0);
                    chk("to_req", {31'h0, bus.dm_req}, 32'h0);
                end
                @(posedge clk);
                #1;
            end
            load_mem = 1'b0;
            chk("to_seen", {31'h0, found}, 32'h1);
            chk("to_cycle", at, 17);
            @(negedge clk);
            chk("to_err_pulse", {31'h0, dm_err}, 32'h0);
            chk("to_resume", {31'h0, mem_stall}, 32'h0);
            @(posedge clk);
            #1;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
